sum_serial_tx: RTL



---
 rtl/sum_serial_tx.sv | 110 +++++++++++
 1 files changed

// File: rtl/sum_serial_tx.sv
// Adds two operands and shifts the carry-inclusive sum out as one UART-style frame:
// start bit, DATA_W+1 data bits LSB first, optional even parity, stop bit.
module sum_serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_EN    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              start,
    output logic              ready,
    output logic              done,
    output logic              tx
);
    localparam int TW = $clog2(CLKS_PER_BIT) + 1;
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [DATA_W:0] sum_q, sum_d;
    logic            par_q, par_d;
    logic            tx_q, tx_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        sum_d   = sum_q;
        par_d   = par_q;

        if (state_q == S_IDLE) begin
            if (start) begin
                sum_d   = {1'b0, a} + {1'b0, b};
                par_d   = ^sum_d;
                state_d = S_START;
                timer_d = '0;
            end
        end else if (timer_q != T_LAST) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = '0;
            case (state_q)
                S_START: begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
                S_DATA: begin
                    if (bit_q == B_LAST) begin
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
                S_PARITY: state_d = S_STOP;
                default:  state_d = S_IDLE;
            endcase
        end

        // Outputs are derived from the next state so they land in flops with no input-to-tx path.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = sum_d[bit_d];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_STOP) && (timer_d == T_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            sum_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            sum_q   <= sum_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign tx    = tx_q;
    assign ready = ready_q;
    assign done  = done_q;
endmodule
